activation_stage: RTL

Post-array activation and packing stage that sits between the systolic array outputs and `sram_controller`'s activation port. It applies a configurable activation function, requantization shift and int8 saturation to each row of array accumulators. It buffers the results in an 8-deep row FIFO. It then drives the controller's `activation_ready` / `activations` / `activated` handshake, one packed 64-bit row per write.

---
 rtl/activation_stage_if.sv | 31 +++
 rtl/activation_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/activation_stage_if.sv
// Signal bundle between the systolic array / control side and activation_stage.
// The master side drives rows and controls. The slave side (the stage) drives the controller handshake and status.
interface activation_stage_if #(
    parameter int NUM_LANES = 8,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       array_valid;
    logic [NUM_LANES*ACC_W-1:0] array_out;
    logic [1:0]                 act_mode;
    logic [3:0]                 shift;
    logic                       flush;
    logic                       activation_ready;
    logic [NUM_LANES*OUT_W-1:0] activations;
    logic                       activated;
    logic [CNT_W-1:0]           rows_pending;
    logic                       overflow_err;

    modport master (
        output array_valid, array_out, act_mode, shift, flush,
        input  activation_ready, activations, activated, rows_pending, overflow_err
    );

    modport slave (
        input  array_valid, array_out, act_mode, shift, flush,
        output activation_ready, activations, activated, rows_pending, overflow_err
    );
endinterface

// File: rtl/activation_stage.sv
// Activation, requantization and int8 saturation of array rows, an 8-deep row FIFO,
// and a batch FSM that feeds packed rows to the sram_controller activation port.
module activation_stage #(
    parameter int NUM_LANES = 8,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 8
) (
    input  logic                clk,
    input  logic                rst,
    activation_stage_if.slave   bus,
    output logic [1:0]          fsm_state
);
    localparam int ROW_W = NUM_LANES * OUT_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ANNOUNCE = 2'd1,
        SEND     = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [ROW_W-1:0] mem [DEPTH];
    logic [ROW_W-1:0] row_in;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, latch_count, batch_left;
    logic             flush_q, push, pop, start;

    function automatic logic [OUT_W-1:0] lane_fn(input logic signed [ACC_W-1:0] x,
                                                 input logic [1:0] mode,
                                                 input logic [3:0] sh);
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] y;
        a = x;
        if (mode == 2'b01 && x < 0) a = '0;
        else if (mode == 2'b10 && x < 0) a = x >>> 3;
        y = a >>> sh;
        if (y > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (y < SAT_LO) return SAT_LO[OUT_W-1:0];
        return y[OUT_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        row_in = '0;
        for (int i = 0; i < NUM_LANES; i++)
            row_in[i*OUT_W +: OUT_W] = lane_fn(bus.array_out[i*ACC_W +: ACC_W], bus.act_mode, bus.shift);
    end

    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign pop   = (state == SEND);
    assign push  = bus.array_valid && ((count < CNT_W'(DEPTH)) || pop);
    assign start = (count == CNT_W'(DEPTH)) || (flush_q && count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= row_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            latch_count      <= '0;
            batch_left       <= '0;
            flush_q          <= 1'b0;
            bus.overflow_err <= 1'b0;
            bus.activations  <= '0;
        end else begin
            flush_q <= bus.flush && (state == IDLE);
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (bus.array_valid && !push) bus.overflow_err <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == IDLE && start) latch_count <= count;
            if (state == ANNOUNCE) batch_left <= latch_count;
            else if (pop)          batch_left <= batch_left - 1'b1;
            if (next_state == SEND) bus.activations <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = ANNOUNCE;
            ANNOUNCE: next_state = SEND;
            SEND:     next_state = GAP;
            GAP:      next_state = (batch_left != '0) ? SEND : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Controller handshake: activation_ready pulses once per batch, then each
    // activated strobe marks one valid activations row, every other cycle; no backpressure.
    always_comb begin
        bus.activation_ready = (state == ANNOUNCE);
        bus.activated        = (state == SEND);
        fsm_state            = state;
    end

    assign bus.rows_pending = count;
endmodule
